fifo_burst_arbiter: RTL and testbench

//  Drains two synchronous FWFT sample FIFOs (ch0 = sub-GHz RX, ch1 = 2.4 GHz RX) into one

---
 rtl/fifo_burst_arbiter.sv | 214 +++++++++++++++++++++
 tb/tb_fifo_burst_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_burst_arbiter.sv
// Drains two FWFT sample FIFOs (ch0 sub-GHz, ch1 2.4 GHz) into one tagged output stream,
// granting whole bursts round-robin from locally tracked occupancy counts.
module fifo_burst_arbiter #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 16,
    parameter int BURST_LEN  = 64
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable_i,
    input  logic                  flush_i,
    input  logic                  ch0_wr_en_i,
    input  logic                  ch1_wr_en_i,
    input  logic                  ch0_empty_i,
    input  logic                  ch1_empty_i,
    input  logic [DATA_WIDTH-1:0] ch0_data_i,
    input  logic [DATA_WIDTH-1:0] ch1_data_i,
    output logic                  ch0_rd_en_o,
    output logic                  ch1_rd_en_o,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic                  out_ch_o,
    output logic                  out_last_o,
    output logic [1:0]            overflow_o,
    input  logic                  clear_ovf_i
);

    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_MAX  = {1'b0, {ADDR_WIDTH{1'b1}}};
    localparam logic [CW-1:0] BURST_C  = CW'(BURST_LEN);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        BURST = 2'b01,
        GAP   = 2'b10
    } state_t;

    state_t                state_r;
    state_t                state_s;
    logic [CW-1:0]         cnt0_r;
    logic [CW-1:0]         cnt1_r;
    logic [CW-1:0]         rem_r;
    logic [CW-1:0]         len_s;
    logic                  grant_r;
    logic                  rr_r;
    logic                  pick_s;
    logic                  start_s;
    logic                  pop_s;
    logic                  head_empty_s;
    logic [DATA_WIDTH-1:0] head_data_s;
    logic [1:0]            elig_s;
    logic [1:0]            ovf_new_s;
    logic [1:0]            overflow_r;
    logic                  out_valid_r;
    logic                  out_ch_r;
    logic                  out_last_r;
    logic [DATA_WIDTH-1:0] out_data_r;

    function automatic logic is_eligible(input logic [CW-1:0] cnt, input logic flush);
        return (cnt >= BURST_C) || (flush && (cnt != CNT_ZERO));
    endfunction

    function automatic logic [CW-1:0] burst_len_of(input logic [CW-1:0] cnt);
        if (cnt < BURST_C) begin
            return cnt;
        end else begin
            return BURST_C;
        end
    endfunction

    // A write into a full FIFO is dropped by the FIFO, so it must not be counted.
    function automatic logic [CW-1:0] next_cnt(input logic [CW-1:0] cnt, input logic wr,
                                               input logic pop);
        logic wr_eff;
        wr_eff = wr && (cnt != CNT_MAX);
        if (wr_eff && !pop) begin
            return cnt + CNT_ONE;
        end else if (!wr_eff && pop) begin
            return cnt - CNT_ONE;
        end else begin
            return cnt;
        end
    endfunction

    // Channel eligibility and round-robin pick starting at rr.
    always_comb begin
        elig_s[0] = is_eligible(cnt0_r, flush_i);
        elig_s[1] = is_eligible(cnt1_r, flush_i);
        if (elig_s[rr_r]) begin
            pick_s = rr_r;
        end else begin
            pick_s = ~rr_r;
        end
        if (pick_s) begin
            len_s = burst_len_of(cnt1_r);
        end else begin
            len_s = burst_len_of(cnt0_r);
        end
        start_s = (state_r == IDLE) && enable_i && (elig_s != 2'b00);
    end

    // Pop strobes: only while words remain, the head is valid and the output slot frees.
    always_comb begin
        if (grant_r) begin
            head_empty_s = ch1_empty_i;
            head_data_s  = ch1_data_i;
        end else begin
            head_empty_s = ch0_empty_i;
            head_data_s  = ch0_data_i;
        end
        pop_s = (state_r == BURST) && (rem_r != CNT_ZERO) && !head_empty_s &&
                (!out_valid_r || out_ready_i);
        ch0_rd_en_o = pop_s && !grant_r;
        ch1_rd_en_o = pop_s && grant_r;
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_s) begin
                    state_s = BURST;
                end else begin
                    state_s = IDLE;
                end
            end
            BURST: begin
                if ((rem_r == CNT_ZERO) && (!out_valid_r || out_ready_i)) begin
                    state_s = GAP;
                end else begin
                    state_s = BURST;
                end
            end
            GAP:     state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Grant, remaining-word count and round-robin pointer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grant_r <= 1'b0;
            rem_r   <= CNT_ZERO;
            rr_r    <= 1'b0;
        end else if (start_s) begin
            grant_r <= pick_s;
            rem_r   <= len_s;
        end else if (pop_s) begin
            rem_r <= rem_r - CNT_ONE;
        end else if (state_r == GAP) begin
            rr_r <= ~grant_r;
        end else begin
            rem_r <= rem_r;
        end
    end

    // Output register: load on pop, drop valid when accepted without a replacement.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_r <= 1'b0;
            out_ch_r    <= 1'b0;
            out_last_r  <= 1'b0;
            out_data_r  <= {DATA_WIDTH{1'b0}};
        end else if (pop_s) begin
            out_valid_r <= 1'b1;
            out_ch_r    <= grant_r;
            out_last_r  <= (rem_r == CNT_ONE);
            out_data_r  <= head_data_s;
        end else if (out_valid_r && out_ready_i) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    // Overflow detection: a write seen while the tracked count is at capacity.
    always_comb begin
        ovf_new_s[0] = ch0_wr_en_i && (cnt0_r == CNT_MAX);
        ovf_new_s[1] = ch1_wr_en_i && (cnt1_r == CNT_MAX);
    end

    // Occupancy counters and sticky overflow; a new overflow wins over clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt0_r     <= CNT_ZERO;
            cnt1_r     <= CNT_ZERO;
            overflow_r <= 2'b00;
        end else begin
            cnt0_r     <= next_cnt(cnt0_r, ch0_wr_en_i, ch0_rd_en_o);
            cnt1_r     <= next_cnt(cnt1_r, ch1_wr_en_i, ch1_rd_en_o);
            overflow_r <= (overflow_r & ~{2{clear_ovf_i}}) | ovf_new_s;
        end
    end

    assign out_valid_o = out_valid_r;
    assign out_ch_o    = out_ch_r;
    assign out_last_o  = out_last_r;
    assign out_data_o  = out_data_r;
    assign overflow_o  = overflow_r;

endmodule

// File: tb/tb_fifo_burst_arbiter.sv
// Scoreboard bench for fifo_burst_arbiter with behavioural FWFT FIFO models on both channels.
module tb_fifo_burst_arbiter;

    localparam int AW  = 10;
    localparam int DW  = 16;
    localparam int BL  = 64;
    localparam int CAP = 1023;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          enable = 1'b0;
    logic          flush = 1'b0;
    logic          wr0 = 1'b0;
    logic          wr1 = 1'b0;
    logic          e0 = 1'b1;
    logic          e1 = 1'b1;
    logic [DW-1:0] d0 = '0;
    logic [DW-1:0] d1 = '0;
    logic          rd0;
    logic          rd1;
    logic          ovalid;
    logic          oready = 1'b1;
    logic [DW-1:0] odata;
    logic          och;
    logic          olast;
    logic [1:0]    ovf;
    logic          clr = 1'b0;

    logic [DW-1:0] wd0 = '0;
    logic [DW-1:0] wd1 = '0;
    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];
    logic [DW+1:0] sb[$];
    logic [DW+1:0] held;
    logic [DW+1:0] exp_w;
    logic [DW-1:0] tmp;

    int  checks = 0;
    int  errors = 0;
    int  accepted = 0;
    int  idle_run = 0;
    bit  stall_prev = 1'b0;
    bit  after_last = 1'b0;
    bit  mon_valid = 1'b0;

    always #5 clk = ~clk;

    fifo_burst_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
        .clk(clk), .reset_n(reset_n), .enable_i(enable), .flush_i(flush),
        .ch0_wr_en_i(wr0), .ch1_wr_en_i(wr1), .ch0_empty_i(e0), .ch1_empty_i(e1),
        .ch0_data_i(d0), .ch1_data_i(d1), .ch0_rd_en_o(rd0), .ch1_rd_en_o(rd1),
        .out_valid_o(ovalid), .out_ready_i(oready), .out_data_o(odata), .out_ch_o(och),
        .out_last_o(olast), .overflow_o(ovf), .clear_ovf_i(clr)
    );

    task automatic drive_heads();
        e0 = (q0.size() == 0);
        e1 = (q1.size() == 0);
        if (q0.size() > 0) d0 = q0[0]; else d0 = '0;
        if (q1.size() > 0) d1 = q1[0]; else d1 = '0;
    endtask

    // One clock: sample and score outputs before the edge, then update the FIFO models.
    task automatic step();
        bit s_rd0, s_rd1, s_wr0, s_wr1;
        #3;
        mon_valid = (ovalid === 1'b1);
        s_rd0 = rd0; s_rd1 = rd1; s_wr0 = wr0; s_wr1 = wr1;
        if (stall_prev) begin
            checks++;
            if (ovalid !== 1'b1 || {och, olast, odata} !== held) begin
                errors++;
                $display("FAIL stall_hold: got v=%b %h required v=1 %h", ovalid, {och, olast, odata}, held);
            end
        end
        if (ovalid === 1'b1 && oready === 1'b0) begin
            checks++;
            if ({rd0, rd1} !== 2'b00) begin
                errors++;
                $display("FAIL stall_pop: got rd=%b required 00", {rd0, rd1});
            end
            stall_prev = 1'b1;
            held = {och, olast, odata};
        end else begin
            stall_prev = 1'b0;
        end
        if (ovalid === 1'b1 && after_last) begin
            checks++;
            if (idle_run < 2) begin
                errors++;
                $display("FAIL burst_gap: got %0d idle clk required >=2", idle_run);
            end
            after_last = 1'b0;
        end
        if (ovalid === 1'b1 && oready === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_word: got ch=%b last=%b data=%h required none", och, olast, odata);
            end else begin
                exp_w = sb.pop_front();
                if ({och, olast, odata} !== exp_w) begin
                    errors++;
                    $display("FAIL word: got ch=%b last=%b data=%h required ch=%b last=%b data=%h",
                             och, olast, odata, exp_w[DW+1], exp_w[DW], exp_w[DW-1:0]);
                end
            end
            accepted++;
            if (olast === 1'b1) after_last = 1'b1;
        end
        if (ovalid === 1'b1) idle_run = 0; else idle_run++;
        @(posedge clk);
        #1;
        if (s_rd0 && q0.size() > 0) tmp = q0.pop_front();
        if (s_rd1 && q1.size() > 0) tmp = q1.pop_front();
        if (s_wr0 && q0.size() < CAP) q0.push_back(wd0);
        if (s_wr1 && q1.size() < CAP) q1.push_back(wd1);
        drive_heads();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        enable = 1'b0; flush = 1'b0; wr0 = 1'b0; wr1 = 1'b0; clr = 1'b0; oready = 1'b1;
        q0.delete(); q1.delete(); sb.delete();
        stall_prev = 1'b0; after_last = 1'b0; idle_run = 0; accepted = 0;
        drive_heads();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic fill(input bit w0, input bit w1, input int n, input int b0, input int b1);
        for (int i = 0; i < n; i++) begin
            wr0 = w0; wr1 = w1;
            wd0 = DW'(b0 + i); wd1 = DW'(b1 + i);
            step();
        end
        wr0 = 1'b0; wr1 = 1'b0;
    endtask

    task automatic expect_burst(input bit ch, input int n, input int base);
        for (int i = 0; i < n; i++) sb.push_back({ch, (i == n - 1), DW'(base + i)});
    endtask

    task automatic run_until(input int target, input int budget, input bit rnd, output bit ok);
        for (int k = 0; k < budget && accepted < target; k++) begin
            if (rnd) oready = 1'($urandom_range(0, 1));
            step();
        end
        ok = (accepted >= target);
        oready = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #2;
        checks++; if (ovalid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b required 0", ovalid); end
        checks++; if (odata !== 16'h0000) begin errors++; $display("FAIL rst_data: got %h required 0000", odata); end
        checks++; if ({och, olast} !== 2'b00) begin errors++; $display("FAIL rst_ch_last: got %b required 00", {och, olast}); end
        checks++; if (ovf !== 2'b00) begin errors++; $display("FAIL rst_ovf: got %b required 00", ovf); end
        checks++; if ({rd0, rd1} !== 2'b00) begin errors++; $display("FAIL rst_rd: got %b required 00", {rd0, rd1}); end
        #8;
    endtask

    task automatic test_single_burst();
        int n;
        int k;
        do_reset();
        enable = 1'b1;
        expect_burst(1'b0, BL, 0);
        fill(1'b1, 1'b0, BL, 0, 0);
        n = 0;
        for (int j = 0; j < 10; j++) begin
            step();
            if (mon_valid) break;
            n++;
        end
        checks++;
        if (n != 2) begin errors++; $display("FAIL grant_latency: got %0d required 2", n); end
        k = 0;
        while (accepted < BL && k < 200) begin step(); k++; end
        checks++;
        if (k != BL - 1) begin errors++; $display("FAIL throughput: got %0d clk required %0d", k, BL - 1); end
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL single_drain: got %0d left required 0", sb.size()); end
        checks++;
        if (dut.cnt0_r !== 11'd0) begin errors++; $display("FAIL single_cnt0: got %0d required 0", dut.cnt0_r); end
    endtask

    task automatic test_round_robin();
        bit ok;
        do_reset();
        fill(1'b1, 1'b1, 2 * BL, 16'h1000, 16'h2000);
        expect_burst(1'b0, BL, 16'h1000);
        expect_burst(1'b1, BL, 16'h2000);
        expect_burst(1'b0, BL, 16'h1000 + BL);
        expect_burst(1'b1, BL, 16'h2000 + BL);
        enable = 1'b1;
        run_until(4 * BL, 800, 1'b0, ok);
        checks++;
        if (!ok || sb.size() != 0) begin errors++; $display("FAIL rr_drain: got %0d words required %0d", accepted, 4 * BL); end
        checks++;
        if ({dut.cnt1_r, dut.cnt0_r} !== 22'd0) begin errors++; $display("FAIL rr_cnt: got %0d/%0d required 0/0", dut.cnt0_r, dut.cnt1_r); end
    endtask

    task automatic test_flush();
        bit ok;
        do_reset();
        enable = 1'b1;
        fill(1'b0, 1'b1, 5, 0, 16'h3000);
        for (int j = 0; j < 20; j++) step();
        checks++;
        if (accepted != 0 || dut.state_r !== 2'b00) begin errors++; $display("FAIL noflush_grant: got %0d words required 0", accepted); end
        expect_burst(1'b1, 5, 16'h3000);
        flush = 1'b1;
        run_until(5, 60, 1'b0, ok);
        flush = 1'b0;
        checks++;
        if (!ok || sb.size() != 0) begin errors++; $display("FAIL flush_drain: got %0d words required 5", accepted); end
        checks++;
        if (dut.cnt1_r !== 11'd0) begin errors++; $display("FAIL flush_cnt1: got %0d required 0", dut.cnt1_r); end
    endtask

    task automatic test_stall();
        bit ok;
        do_reset();
        fill(1'b1, 1'b0, BL, 16'h4000, 0);
        expect_burst(1'b0, BL, 16'h4000);
        enable = 1'b1;
        run_until(BL, 2000, 1'b1, ok);
        checks++;
        if (!ok || sb.size() != 0) begin errors++; $display("FAIL stall_drain: got %0d words required %0d", accepted, BL); end
    endtask

    task automatic test_overflow();
        do_reset();
        fill(1'b1, 1'b0, CAP, 0, 0);
        checks++;
        if (ovf !== 2'b00) begin errors++; $display("FAIL ovf_early: got %b required 00", ovf); end
        fill(1'b1, 1'b0, 1, 0, 0);
        checks++;
        if (ovf !== 2'b01) begin errors++; $display("FAIL ovf_set: got %b required 01", ovf); end
        checks++;
        if (dut.cnt0_r !== 11'd1023) begin errors++; $display("FAIL ovf_cnt0: got %0d required 1023", dut.cnt0_r); end
        clr = 1'b1;
        fill(1'b1, 1'b0, 1, 0, 0);
        clr = 1'b0;
        checks++;
        if (ovf !== 2'b01) begin errors++; $display("FAIL ovf_clr_race: got %b required 01", ovf); end
        clr = 1'b1;
        step();
        clr = 1'b0;
        checks++;
        if (ovf !== 2'b00) begin errors++; $display("FAIL ovf_clear: got %b required 00", ovf); end
        checks++;
        if (dut.cnt0_r !== 11'd1023) begin errors++; $display("FAIL ovf_cnt_hold: got %0d required 1023", dut.cnt0_r); end
    endtask

    task automatic test_reset_mid_burst();
        bit ok;
        do_reset();
        fill(1'b1, 1'b0, BL, 16'h6000, 0);
        expect_burst(1'b0, BL, 16'h6000);
        enable = 1'b1;
        run_until(20, 200, 1'b0, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL mid_reach: got %0d words required 20", accepted); end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({ovalid, och, olast, odata} !== 19'd0) begin errors++; $display("FAIL mid_rst_out: got v=%b data=%h required 0", ovalid, odata); end
        checks++;
        if ({rd0, rd1} !== 2'b00) begin errors++; $display("FAIL mid_rst_rd: got %b required 00", {rd0, rd1}); end
        do_reset();
        enable = 1'b1;
        for (int j = 0; j < 5; j++) step();
        checks++;
        if (dut.state_r !== 2'b00 || dut.rr_r !== 1'b0) begin errors++; $display("FAIL mid_state: got st=%b rr=%b required 00/0", dut.state_r, dut.rr_r); end
        checks++;
        if ({dut.cnt1_r, dut.cnt0_r} !== 22'd0 || accepted != 0) begin errors++; $display("FAIL mid_cnt: got %0d/%0d words=%0d required 0", dut.cnt0_r, dut.cnt1_r, accepted); end
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_round_robin();
        test_flush();
        test_stall();
        test_overflow();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
